// File: rtl/gpio_in_pkg.sv
// Shared constants for the GPIO input port: register offsets inside the
// 4-byte window and field widths used by the debounce logic.
package gpio_in_pkg;

    // Byte offsets from BASE_ADDR of the two 16-bit registers
    localparam logic [1:0] REG_STAT = 2'd0;
    localparam logic [1:0] REG_EN   = 2'd2;

    // Register field width (one byte per field)
    localparam int FIELD_W = 8;

    // Debounce counter width, enough for DEB_CNT up to 15
    localparam int CNT_W = 4;

endpackage

// File: rtl/gpio_in_debounce.sv
// One pin: 2-flop synchroniser, tick-sampled debounce counter, stable level
// and single-cycle rise/fall pulses when a new level is accepted.
// Ports: sys_clk, rst_n, pin_i (raw), tick_i (sample strobe),
//        level_o (debounced), rise_o / fall_o (1-cycle edge events).
module gpio_in_debounce
    import gpio_in_pkg::*;
#(
    parameter int DEB_CNT = 4
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic pin_i,
    input  logic tick_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             level_q;
    logic             level_d;
    logic             accept;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        accept  = 1'b0;
        cnt_inc = cnt_q + 1'b1;
        if (tick_i) begin
            if (sync2_q == level_q) begin
                // any sample matching the current level restarts the count
                cnt_d = '0;
            end else if (cnt_inc == CNT_W'(DEB_CNT)) begin
                level_d = sync2_q;
                cnt_d   = '0;
                accept  = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // Edge pulses coincide with the cycle the new level is loaded
    assign rise_o  = accept & sync2_q;
    assign fall_o  = accept & ~sync2_q;
    assign level_o = level_q;

endmodule

// File: rtl/gpio_in_port.sv
// Memory-mapped debounced GPIO input port with W1C edge flags and irq.
// Ports: sys_clk, rst_n, pin_in[WIDTH], dmem_addr/wen/byt/wdata (CPU bus),
//        dmem_rdata (data for last cycle's address, 0 when not addressed),
//        irq (registered OR of edge flags). Register layout assumes WIDTH=8.
module gpio_in_port
    import gpio_in_pkg::*;
#(
    parameter int WIDTH      = FIELD_W,
    parameter int BASE_ADDR  = 'h084,
    parameter int TICK_DIV   = 27000,
    parameter int DEB_CNT    = 4,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      pin_in,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic                  dmem_wen,
    input  logic                  dmem_byt,
    input  logic [15:0]           dmem_wdata,
    output logic [15:0]           dmem_rdata,
    output logic                  irq
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(4);

    logic [TW-1:0]         tick_q;
    logic                  tick;

    logic [WIDTH-1:0]      level;
    logic [WIDTH-1:0]      rise;
    logic [WIDTH-1:0]      fall;

    logic [WIDTH-1:0]      flag_q;
    logic [WIDTH-1:0]      flag_d;
    logic [WIDTH-1:0]      rise_en_q;
    logic [WIDTH-1:0]      rise_en_d;
    logic [WIDTH-1:0]      fall_en_q;
    logic [WIDTH-1:0]      fall_en_d;
    logic [WIDTH-1:0]      clr;
    logic [WIDTH-1:0]      set_v;
    logic                  irq_q;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] wsub;
    logic [ADDR_WIDTH-1:0] rsub;
    logic                  whit;
    logic                  rhit;
    logic                  stat_wr;
    logic                  en_wr;

    // Debounce sample strobe, one cycle per TICK_DIV cycles
    assign tick = (tick_q == TW'(TICK_DIV - 1));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else if (tick) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_in_debounce #(
            .DEB_CNT (DEB_CNT)
        ) u_deb (
            .sys_clk (sys_clk),
            .rst_n   (rst_n),
            .pin_i   (pin_in[i]),
            .tick_i  (tick),
            .level_o (level[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

    // Write decode; bit 1 of the offset picks the register
    assign wsub    = dmem_addr - BASE;
    assign whit    = (dmem_addr >= BASE) && (wsub < SPAN);
    assign stat_wr = dmem_wen && whit && (wsub[1] == REG_STAT[1]);
    assign en_wr   = dmem_wen && whit && (wsub[1] == REG_EN[1]);

    always_comb begin
        clr       = '0;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        // a byte write to the level byte is ignored
        if (stat_wr && (!dmem_byt || wsub[0])) begin
            clr = dmem_wdata[15:8];
        end
        if (en_wr) begin
            if (!dmem_byt) begin
                rise_en_d = dmem_wdata[7:0];
                fall_en_d = dmem_wdata[15:8];
            end else if (wsub[0]) begin
                fall_en_d = dmem_wdata[15:8];
            end else begin
                rise_en_d = dmem_wdata[7:0];
            end
        end
    end

    // A new edge beats a W1C on the same bit
    assign set_v  = (rise & rise_en_q) | (fall & fall_en_q);
    assign flag_d = (flag_q & ~clr) | set_v;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            irq_q     <= 1'b0;
            addr_q    <= '0;
        end else begin
            flag_q    <= flag_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            irq_q     <= |flag_q;
            addr_q    <= dmem_addr;
        end
    end

    // Read path from the registered address; odd addresses alias the word
    assign rsub = addr_q - BASE;
    assign rhit = (addr_q >= BASE) && (rsub < SPAN);

    always_comb begin
        dmem_rdata = 16'h0000;
        if (rhit) begin
            if (rsub[1] == REG_EN[1]) begin
                dmem_rdata = {fall_en_q, rise_en_q};
            end else begin
                dmem_rdata = {flag_q, level};
            end
        end
    end

    assign irq = irq_q;

endmodule
